// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply / restoring divide unit with valid/ready handshake and flush.
// Optional MDU_ZERO_BYPASS_EN: zero-operand MUL-class and divide-by-zero ops finish one cycle after accept.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_divzero
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  state_t r_state, w_state_next;

  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [TAG_W-1:0] r_tag;
  logic [WIDTH-1:0] r_a, r_hi, r_lo, r_result;
  logic             r_neg_res, r_neg_rem, r_divzero;

  logic             w_accept, w_last, w_bypass;
  logic             w_in_div, w_in_signed, w_s1, w_s2, w_in_dz;
  logic [WIDTH-1:0] w_m1, w_m2;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) as unsigned.
  assign w_in_div    = (in_op >= 3'd3) && (in_op <= 3'd6);
  assign w_in_signed = (in_op == 3'd0) || (in_op == 3'd1) || (in_op == 3'd3) || (in_op == 3'd5);
  assign w_s1        = w_in_signed & in_src1[WIDTH-1];
  assign w_s2        = w_in_signed & in_src2[WIDTH-1];
  assign w_m1        = w_s1 ? -in_src1 : in_src1;
  assign w_m2        = w_s2 ? -in_src2 : in_src2;
  assign w_in_dz     = w_in_div && (in_src2 == '0);

`ifdef MDU_ZERO_BYPASS_EN
  logic [WIDTH-1:0] w_byp_result;
  assign w_bypass = w_in_dz ||
                    ((in_op <= 3'd2) && ((in_src1 == '0) || (in_src2 == '0)));
  assign w_byp_result = w_in_dz ? (((in_op == 3'd3) || (in_op == 3'd4)) ? '1 : in_src1) : '0;
`else
  assign w_bypass = 1'b0;
`endif

  // Shared iteration: r_hi is product-high / remainder, r_lo is multiplier / quotient.
  logic             w_is_div, w_ge;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_shift, w_trial, w_hi_next, w_lo_next;
  logic [2*WIDTH-1:0] w_prod, w_prod_s;
  logic [WIDTH-1:0] w_quo_s, w_rem_s, w_result;

  assign w_is_div  = (r_op >= 3'd3) && (r_op <= 3'd6);
  assign w_sum     = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_a}) : {1'b0, r_hi};
  assign w_shift   = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
  assign w_trial   = w_shift - r_a;
  assign w_ge      = {r_hi[WIDTH-1], w_shift} >= {1'b0, r_a};
  assign w_hi_next = w_is_div ? (w_ge ? w_trial : w_shift) : w_sum[WIDTH:1];
  assign w_lo_next = w_is_div ? {r_lo[WIDTH-2:0], w_ge} : {w_sum[0], r_lo[WIDTH-1:1]};

  assign w_prod    = {w_hi_next, w_lo_next};
  assign w_prod_s  = r_neg_res ? -w_prod : w_prod;
  assign w_quo_s   = r_neg_res ? -w_lo_next : w_lo_next;
  assign w_rem_s   = r_neg_rem ? -w_hi_next : w_hi_next;
  assign w_last    = (r_cnt == LAST);

  always_comb begin
    w_result = '0;
    case (r_op)
      3'd0:       w_result = w_prod_s[WIDTH-1:0];
      3'd1, 3'd2: w_result = w_prod_s[2*WIDTH-1:WIDTH];
      3'd3, 3'd4: w_result = r_divzero ? '1 : w_quo_s;
      3'd5, 3'd6: w_result = w_rem_s;
      default:    w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      S_IDLE: if (in_valid && !flush) begin
        w_accept     = 1'b1;
        w_state_next = w_bypass ? S_DONE : S_BUSY;
      end
      S_BUSY:  if (w_last) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    if (flush) w_state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt <= '0; r_op <= '0; r_tag <= '0; r_a <= '0; r_hi <= '0; r_lo <= '0;
      r_result <= '0; r_neg_res <= 1'b0; r_neg_rem <= 1'b0; r_divzero <= 1'b0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt     <= '0;
      r_op      <= in_op;
      r_tag     <= in_tag;
      r_hi      <= '0;
      r_a       <= w_in_div ? w_m2 : w_m1;
      r_lo      <= w_in_div ? w_m1 : w_m2;
      r_neg_res <= w_s1 ^ w_s2;
      r_neg_rem <= w_s1;
      r_divzero <= w_in_dz;
`ifdef MDU_ZERO_BYPASS_EN
      if (w_bypass) r_result <= w_byp_result;
`endif
    end else if (r_state == S_BUSY) begin
      r_hi  <= w_hi_next;
      r_lo  <= w_lo_next;
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (w_last) r_result <= w_result;
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign out_result  = r_result;
  assign out_tag     = r_tag;
  assign out_divzero = r_divzero;
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit for the EX stage; replaces the fixed 32-bit booth multiplier plus divider IP pair.
- Radix-2 shift-add multiply and restoring divide share one datapath and one counter.
- Valid/ready handshake on both sides; flush input for exception/branch cancel; opaque tag carried with the result.
- One operation in flight at a time.

Parameters:
WIDTH, 32, operand/result width in bits (>=8, even)
TAG_W, 5, width of the pass-through tag (e.g. dest register index)

Ports:
clk  input  1  clock
resetn  input  1  synchronous active-low reset
flush  input  1  cancel in-flight op; drop any held result
in_valid  input  1  request valid
in_ready  output  1  unit can accept (high only in IDLE)
in_op  input  3  0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 MOD, 6 MODU, 7 reserved
in_src1  input  WIDTH  multiplicand / dividend
in_src2  input  WIDTH  multiplier / divisor
in_tag  input  TAG_W  tag, returned unchanged
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  result
out_tag  output  TAG_W  tag of this result
out_divzero  output  1  DIV/DIVU/MOD/MODU with src2==0

Behaviour:
- Clock and reset: clk; reset resetn, synchronous, active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_result=0, out_tag=0, out_divzero=0, counter=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: accept on posedge with in_valid&in_ready&~flush; latch op, tag, operand magnitudes and result signs; go to BUSY with cnt=0.
  - BUSY: one iteration per cycle. On the cycle with cnt==WIDTH-1, perform the last iteration, sign-correct, register out_result and go to DONE. Latency: out_valid high exactly WIDTH cycles after the accepting edge.
  - DONE: out_valid=1; outputs stable until out_valid&out_ready; then go to IDLE. No accept in the same cycle (in_ready=0 in DONE).
- Signedness:
  - MUL/MULH/DIV/MOD: signed. Magnitudes taken at accept.
  - Product sign = s1^s2. Quotient sign = s1^s2. Remainder sign = sign of dividend.
  - MULHU/DIVU/MODU: unsigned.
  - Product kept at 2*WIDTH bits; MUL returns the low half, MULH/MULHU the high half.
  - Magnitude of the most negative value is handled as unsigned WIDTH-bit 2^(WIDTH-1); no extra bit is lost.
- Boundary cases:
  - Divide by zero: quotient = all ones; remainder = src1; out_divzero=1. Still takes the full WIDTH cycles.
  - Signed overflow (src1 = MIN, src2 = -1): quotient = MIN, remainder = 0, out_divzero=0.
  - op 7: result 0, out_divzero=0, normal WIDTH latency.
- Flush:
  - Synchronous; highest priority after reset.
  - In any state: next state IDLE, out_valid=0, counter=0; result and tag registers may hold stale data.
  - A request presented in the same cycle as flush is not accepted.
- Simultaneous events:
  - flush & out_ready in DONE: treated as flush, no handshake counted.
  - Reset mid-operation: all state returns to reset values next edge.
- Inputs are sampled only at accept; changes to in_* during BUSY have no effect.

Optional Feature:
MDU_ZERO_BYPASS_EN
- Defined: at accept, if op is MUL-class and either source is 0, or op is DIV-class and src2==0, skip BUSY.
  - Register the final result directly and enter DONE, so out_valid is high 1 cycle after accept.
  - Result values and out_divzero are identical to the non-bypass case.
- Undefined: no bypass logic; every op takes WIDTH cycles.

Test Plan:
- WIDTH=32. MUL 0xFFFFFFFF*0x00000003 -> 0xFFFFFFFD. MULH same operands -> 0xFFFFFFFF. MULHU same operands -> 0x00000002. Each has out_valid exactly 32 cycles after accept and out_tag echoed.
- DIV -7/2 -> 0xFFFFFFFD; MOD -7/2 -> 0xFFFFFFFF. DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC; MODU same operands -> 1.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and MOD of the same -> 0. DIVU 5/0 -> 0xFFFFFFFF with out_divzero=1; MODU 5/0 -> 5.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_result/out_tag stable, in_ready=0. Then out_ready=1 -> IDLE next cycle, in_ready=1, and a back-to-back request is accepted.
- Flush at cnt=10 during DIV -> IDLE next cycle, no out_valid. A new MUL 6*7 then returns 42. Also: flush together with in_valid in IDLE -> no accept.
- With MDU_ZERO_BYPASS_EN: MUL 0*x -> 0 one cycle after accept; DIV x/0 -> 0xFFFFFFFF with divzero=1 one cycle after accept. Without the macro: same values after 32 cycles.
